// File: rtl/req_encoder_148.sv
// req_encoder_148 -- registered 8:3 priority encoder with sticky request
// capture and an acknowledge/timeout grant handshake.
//
// Requests on I_L are latched into a sticky pending register. While enabled
// (EI_L low), the highest-priority pending request is granted. A grant is
// presented on A_L/GS_L/VALID until ACK is seen or ACK_TIMEOUT cycles pass.
// A one-cycle release gap always follows a grant.
//
// Build option: define ROTATE_PRI_EN for round-robin priority. After an
// ACKed grant of idx, the next search starts at idx-1 and moves downward
// with wrap. When it is undefined, priority is fixed with bit 7 highest.
//
// Parameters:
//   ACK_TIMEOUT  GRANT cycles without ACK before the grant is abandoned (1..255)
// Ports:
//   CLK      rising-edge clock
//   RESET_L  asynchronous active-low reset
//   EI_L     active-low enable; new grants start only while low
//   I_L[7:0] active-low request lines
//   ACK      acknowledge of the current grant; only honoured in GRANT
//   A_L[2:0] active-low encoded index of the grant (3'b111 when idle)
//   GS_L     active-low group select, low while a grant is presented
//   VALID    active-high copy of ~GS_L
//   EO_L     active-low "enabled and nothing pending"
//   TMO      one-cycle pulse when a grant is abandoned on timeout
module req_encoder_148 #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       EI_L,
  input  logic [7:0] I_L,
  input  logic       ACK,
  output logic [2:0] A_L,
  output logic       GS_L,
  output logic       VALID,
  output logic       EO_L,
  output logic       TMO
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] a_l_q, a_l_d;
  logic       gs_l_q, gs_l_d;
  logic       valid_q, valid_d;
  logic       eo_l_q, eo_l_d;
  logic       tmo_q, tmo_d;
  logic [2:0] search_start;

`ifdef ROTATE_PRI_EN
  logic [2:0] ptr_q, ptr_d;
  assign search_start = ptr_q;
`else
  assign search_start = 3'd7;
`endif

  // Search downward from 'start' with wrap. The loop runs from the farthest
  // candidate to the nearest one so that the nearest set bit is written last
  // and therefore wins.
  function automatic logic [2:0] pick_idx(input logic [7:0] req,
                                          input logic [2:0] start);
    logic [2:0] cand;
    pick_idx = start;
    for (int unsigned k = 8; k > 0; k--) begin
      cand = start - 3'(k - 1);
      if (req[cand]) pick_idx = cand;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | ~I_L;
    idx_d     = idx_q;
    timer_d   = timer_q;
    tmo_d     = 1'b0;
`ifdef ROTATE_PRI_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!EI_L && (pending_q != '0)) begin
          idx_d   = pick_idx(pending_q, search_start);
          timer_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ACK) begin
          // The clear overrides a same-cycle set from I_L. A request that is
          // still held low sets the bit again on the next edge.
          pending_d[idx_q] = 1'b0;
          state_d          = RELEASE;
`ifdef ROTATE_PRI_EN
          ptr_d            = idx_q - 3'd1;
`endif
        end else if (timer_q == TIMER_LAST) begin
          tmo_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are a registered decode of the current state. The grant is
    // therefore visible one cycle after the edge that enters GRANT, and it
    // stays visible for exactly as many cycles as GRANT lasts.
    a_l_d   = (state_q == GRANT) ? ~idx_q : '1;
    gs_l_d  = (state_q != GRANT);
    valid_d = (state_q == GRANT);
    eo_l_d  = ~(~EI_L && (pending_q == '0));
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      a_l_q     <= '1;
      gs_l_q    <= 1'b1;
      valid_q   <= 1'b0;
      eo_l_q    <= 1'b1;
      tmo_q     <= 1'b0;
`ifdef ROTATE_PRI_EN
      ptr_q     <= 3'd7;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      a_l_q     <= a_l_d;
      gs_l_q    <= gs_l_d;
      valid_q   <= valid_d;
      eo_l_q    <= eo_l_d;
      tmo_q     <= tmo_d;
`ifdef ROTATE_PRI_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign A_L   = a_l_q;
  assign GS_L  = gs_l_q;
  assign VALID = valid_q;
  assign EO_L  = eo_l_q;
  assign TMO   = tmo_q;

endmodule
